// File: rtl/rv32ima_pkg.sv
// Shared RV32 types for the fetch front end: state encoding, buffered fetch entry, NOP word.
package rv32ima_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    STALL,
    REQ,
    DROP,
    HALT
  } ifetch_state_t;

  typedef struct packed {
    word_t pc;
    word_t inst;
    logic  fault;
  } fetch_entry_t;

  localparam word_t RV32_NOP = 32'h0000_0013;

  function automatic word_t word_align(input word_t a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Fetch buffer of fetch_entry_t; head is a stored register, one cycle from push to visible head.
// Push and pop may coincide; flush wins over push and clears on the next edge.
module ifetch_fifo
  import rv32ima_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  fetch_entry_t            push_entry,
  input  logic                    pop,
  input  logic                    flush,
  output fetch_entry_t            head,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_entry;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: PC, single-outstanding imem requests, fetch FIFO; imem_ready at N -> inst_valid at N+1.
// Stops requesting while the FIFO is full; IFETCH_ALIGN_CHECK_EN adds misaligned-redirect fault entries.
module ifetch_unit
  import rv32ima_pkg::*;
#(
  parameter word_t RESET_PC   = 32'h0000_0000,
  parameter int    FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  output logic         imem_ren,
  output logic [31:0]  imem_addr,
  input  logic         imem_ready,
  input  logic [31:0]  imem_rdata,
  input  logic         redirect_en,
  input  logic [31:0]  redirect_pc,
  output logic         inst_valid,
  input  logic         inst_ready,
  output logic [31:0]  inst,
  output logic [31:0]  inst_pc,
  output logic         inst_fault
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
`ifdef IFETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  ifetch_state_t state;
  word_t         pc;
  word_t         req_addr;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] post_count;
  logic          push;
  logic          pop;
  logic          accept;
  logic          outstanding;
  word_t         tgt;

  assign imem_ren    = (state == REQ) || (state == DROP);
  assign imem_addr   = req_addr;
  assign outstanding = imem_ren && !imem_ready;
  assign inst_valid  = (fifo_count != '0);
  assign pop         = inst_valid && inst_ready && !redirect_en;
  assign accept      = (state == REQ) && imem_ready && !redirect_en;
  assign post_count  = fifo_count + CW'(1) - CW'(pop);
  assign tgt         = ALIGN_CHK ? redirect_pc : word_align(redirect_pc);

`ifdef IFETCH_ALIGN_CHECK_EN
  logic halt_done;
  logic halt_push;
  logic tgt_bad;
  assign tgt_bad   = (redirect_pc[1:0] != 2'b00);
  assign halt_push = (state == HALT) && !halt_done && !redirect_en;
`endif

  always_comb begin
    push       = accept;
    push_entry = '{pc: req_addr, inst: imem_rdata, fault: 1'b0};
`ifdef IFETCH_ALIGN_CHECK_EN
    if (halt_push) begin
      push       = 1'b1;
      push_entry = '{pc: pc, inst: RV32_NOP, fault: 1'b1};
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= STALL;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
`ifdef IFETCH_ALIGN_CHECK_EN
      halt_done <= 1'b0;
`endif
    end else if (redirect_en) begin
      pc <= tgt;
      // An in-flight request must still complete; its data is dropped.
      if (outstanding) begin
        state <= DROP;
`ifdef IFETCH_ALIGN_CHECK_EN
      end else if (tgt_bad) begin
        state     <= HALT;
        halt_done <= 1'b0;
`endif
      end else begin
        state    <= REQ;
        req_addr <= tgt;
      end
    end else begin
      case (state)
        STALL: begin
          if (fifo_count < DEPTH_C) begin
            state    <= REQ;
            req_addr <= pc;
          end
        end
        REQ: begin
          if (imem_ready) begin
            pc <= pc + 32'd4;
            if (post_count < DEPTH_C) req_addr <= pc + 32'd4;
            else                      state    <= STALL;
          end
        end
        DROP: begin
          if (imem_ready) begin
`ifdef IFETCH_ALIGN_CHECK_EN
            if (pc[1:0] != 2'b00) begin
              state     <= HALT;
              halt_done <= 1'b0;
            end else begin
              state    <= REQ;
              req_addr <= pc;
            end
`else
            state    <= REQ;
            req_addr <= pc;
`endif
          end
        end
`ifdef IFETCH_ALIGN_CHECK_EN
        HALT: halt_done <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

  ifetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_en),
    .head       (head),
    .count      (fifo_count)
  );

  assign inst       = head.inst;
  assign inst_pc    = head.pc;
  assign inst_fault = ALIGN_CHK & head.fault;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios then random traffic against a queue-based fetch model.
module tb_ifetch_unit;

  localparam int          DEPTH   = 4;
  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP     = 32'h0000_0013;
`ifdef IFETCH_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_ren;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;

  int total = 0;
  int bad   = 0;

  // Reference model: a request is either out on the bus or not, possibly marked for discard.
  logic [64:0] m_q[$];
  logic [31:0] m_pc, m_addr;
  bit          m_out, m_discard, m_halted, m_halt_pend;

  ifetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_ren    (imem_ren),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_fault  (inst_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc = RST_PC; m_addr = RST_PC;
    m_out = 0; m_discard = 0; m_halted = 0; m_halt_pend = 0;
  endtask

  task automatic model_step(input bit rdy, input bit ren, input logic [31:0] rpc,
                            input bit irdy, input logic [31:0] rd);
    int          sz0;
    bit          pop;
    logic [31:0] tgt;
    sz0 = m_q.size();
    pop = (sz0 > 0) && irdy && !ren;
    if (ren) begin
      m_q.delete();
      tgt  = ALIGN ? rpc : (rpc & 32'hFFFF_FFFC);
      m_pc = tgt;
      if (m_out && !rdy) m_discard = 1;
      else if (ALIGN && (tgt % 4 != 0)) begin
        m_out = 0; m_discard = 0; m_halted = 1; m_halt_pend = 1;
      end else begin
        m_out = 1; m_addr = tgt; m_discard = 0; m_halted = 0; m_halt_pend = 0;
      end
    end else begin
      if (pop) void'(m_q.pop_front());
      if (m_out && rdy) begin
        if (m_discard) begin
          m_discard = 0;
          if (m_pc % 4 != 0) begin m_out = 0; m_halted = 1; m_halt_pend = 1; end
          else m_addr = m_pc;
        end else begin
          m_q.push_back({m_addr, rd, 1'b0});
          m_pc = m_pc + 32'd4;
          if (m_q.size() < DEPTH) m_addr = m_pc;
          else m_out = 0;
        end
      end else if (!m_out && !m_halted) begin
        if (sz0 < DEPTH) begin m_out = 1; m_addr = m_pc; end
      end else if (m_halted && m_halt_pend) begin
        m_q.push_back({m_pc, NOP, 1'b1});
        m_halt_pend = 0;
      end
    end
  endtask

  task automatic check_outputs();
    logic [64:0] e;
    chk("imem_ren", imem_ren, m_out);
    if (m_out) chk("imem_addr", imem_addr, m_addr);
    chk("inst_valid", inst_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      e = m_q[0];
      chk("inst", inst, e[32:1]);
      chk("inst_pc", inst_pc, e[64:33]);
      chk("inst_fault", inst_fault, e[0]);
    end
  endtask

  // Called at a falling edge; applies one cycle of inputs and checks the result.
  task automatic step(input bit rdy, input bit ren, input logic [31:0] rpc, input bit irdy);
    logic [31:0] rd;
    bit          r;
    rd = $urandom;
    r  = rdy && m_out;
    imem_ready = r; imem_rdata = rd;
    redirect_en = ren; redirect_pc = rpc; inst_ready = irdy;
    model_step(r, ren, rpc, irdy, rd);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_ready = 0; redirect_en = 0; inst_ready = 0;
    model_reset();
    #1;
    chk("rst_ren", imem_ren, 1'b0);
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_fault", inst_fault, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] rpc;
    @(negedge clk);
    do_reset();

    // Streaming with everything ready.
    repeat (30) step(1, 0, 0, 1);
    // Decoder stalled: fill to depth, one pop, refill.
    repeat (12) step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    repeat (6) step(1, 0, 0, 0);
    repeat (8) step(1, 0, 0, 1);
    // Redirect while a request waits on imem.
    step(0, 1, 32'h0000_0100, 1);
    repeat (3) step(0, 0, 0, 1);
    repeat (6) step(1, 0, 0, 1);
    // Redirect coinciding with a response.
    step(1, 1, 32'h0000_0240, 1);
    repeat (4) step(1, 0, 0, 1);
    // Address wrap past the top of memory.
    step(1, 1, 32'hFFFF_FFF4, 1);
    repeat (6) step(1, 0, 0, 1);
    // Misaligned target, then aligned recovery.
    step(1, 1, 32'h0000_0102, 1);
    repeat (5) step(1, 0, 0, 0);
    step(1, 1, 32'h0000_0200, 1);
    repeat (5) step(1, 0, 0, 1);

    repeat (3000) begin
      rpc = ($urandom % 2) ? $urandom : ($urandom % 64);
      step(($urandom % 4) != 0, ($urandom % 12) == 0, rpc, ($urandom % 3) != 0);
    end

    // Reset in the middle of traffic.
    repeat (3) step(0, 0, 0, 0);
    do_reset();
    repeat (10) step(1, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
